// File: rtl/adxl355_spi_arbiter.sv
// Single-owner arbiter for the ADXL355 SPI port, shared by the SYNC-driven
// sample reader and the asynchronous ESP32 host, with CSn-high gap and statistics.
module adxl355_spi_arbiter #(
    parameter int GAP_CYCLES    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AUTO_WAIT_MAX = 400,
    parameter int CNT_BITS      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                auto_req,
    output logic                auto_grant,
    input  logic                auto_csn,
    input  logic                auto_sclk,
    input  logic                auto_mosi,
    output logic                auto_miso,
    input  logic                host_csn,
    input  logic                host_sclk,
    input  logic                host_mosi,
    output logic                host_miso,
    output logic                host_busy,
    output logic                adxl_csn,
    output logic                adxl_sclk,
    output logic                adxl_mosi,
    input  logic                adxl_miso,
    output logic [1:0]          owner,
    output logic [CNT_BITS-1:0] auto_miss_cnt,
    output logic [CNT_BITS-1:0] host_drop_cnt
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int WW = $clog2(AUTO_WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AUTO = 2'd1,
        ST_HOST = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_auto_grant;
    logic                   r_host_sel;
    logic [GW-1:0]          r_gap_cnt;
    logic [SYNC_STAGES-1:0] r_hsync;
    logic [SYNC_STAGES-1:0] r_valid_sr;
    logic                   r_hcs_d;
    logic                   r_hcs_arm;
    logic [WW-1:0]          r_wait_cnt;
    logic [CNT_BITS-1:0]    r_miss_cnt;
    logic [CNT_BITS-1:0]    r_drop_cnt;

    logic w_hcs;
    logic w_host_start;
    logic w_host_rise;
    logic w_drop;
    logic w_waiting;

    assign w_hcs        = r_hsync[SYNC_STAGES-1];
    // A start needs hcs to have been genuinely high, so a csn held low across reset never grants.
    assign w_host_start = r_hcs_arm & ~w_hcs;
    assign w_host_rise  = ~r_hcs_d & w_hcs;
    assign w_drop       = w_host_start & ((r_state != ST_IDLE) | auto_req);
    assign w_waiting    = auto_req & (r_state != ST_AUTO);

    // host_csn synchronizer, edge history and post-reset arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync    <= '1;
            r_valid_sr <= '0;
            r_hcs_d    <= 1'b1;
            r_hcs_arm  <= 1'b0;
        end else begin
            r_hsync    <= {r_hsync[SYNC_STAGES-2:0], host_csn};
            r_valid_sr <= {r_valid_sr[SYNC_STAGES-2:0], 1'b1};
            r_hcs_d    <= w_hcs;
            r_hcs_arm  <= w_hcs & r_valid_sr[SYNC_STAGES-1];
        end
    end

    // Ownership state machine with registered select/grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_auto_grant <= 1'b0;
            r_host_sel   <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (auto_req) begin
                        r_state      <= ST_AUTO;
                        r_auto_grant <= 1'b1;
                    end else if (w_host_start) begin
                        r_state    <= ST_HOST;
                        r_host_sel <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_AUTO: begin
                    if (!auto_req) begin
                        r_state      <= ST_GAP;
                        r_auto_grant <= 1'b0;
                        r_gap_cnt    <= GW'(GAP_CYCLES - 1);
                    end else begin
                        r_state <= ST_AUTO;
                    end
                end
                ST_HOST: begin
                    if (w_host_rise) begin
                        r_state    <= ST_GAP;
                        r_host_sel <= 1'b0;
                        r_gap_cnt  <= GW'(GAP_CYCLES - 1);
                    end else begin
                        r_state <= ST_HOST;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GW'(0)) begin
                        if (auto_req) begin
                            r_state      <= ST_AUTO;
                            r_auto_grant <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_auto_grant <= 1'b0;
                    r_host_sel   <= 1'b0;
                end
            endcase
        end
    end

    // Auto wait timer and saturating miss/drop statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_miss_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_waiting) begin
                if (r_wait_cnt != WW'(AUTO_WAIT_MAX)) begin
                    r_wait_cnt <= r_wait_cnt + WW'(1);
                    if ((r_wait_cnt == WW'(AUTO_WAIT_MAX - 1)) && (r_miss_cnt != {CNT_BITS{1'b1}})) begin
                        r_miss_cnt <= r_miss_cnt + CNT_BITS'(1);
                    end
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_drop && (r_drop_cnt != {CNT_BITS{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_BITS'(1);
            end
        end
    end

    assign adxl_csn      = r_host_sel ? host_csn  : (r_auto_grant ? auto_csn  : 1'b1);
    assign adxl_sclk     = r_host_sel ? host_sclk : (r_auto_grant ? auto_sclk : 1'b1);
    assign adxl_mosi     = r_host_sel ? host_mosi : (r_auto_grant ? auto_mosi : 1'b0);
    assign auto_miso     = r_auto_grant ? adxl_miso : 1'b1;
    assign host_miso     = r_host_sel   ? adxl_miso : 1'b1;
    assign auto_grant    = r_auto_grant;
    assign owner         = r_state;
    assign host_busy     = (r_state != ST_IDLE) | auto_req;
    assign auto_miss_cnt = r_miss_cnt;
    assign host_drop_cnt = r_drop_cnt;

endmodule
